// File: rtl/lsu_pkg.sv
// Shared definitions for the lsu_mem data-memory load/store unit:
// RISC-V funct3 width codes, FSM state encoding and wait-state counter width.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_mem_array.sv
// Word-organised data storage: byte-enable synchronous write, registered word read.
// Contents are intentionally not reset.
module lsu_mem_array
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic [3:0]            wr_be,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [31:0]           rd_data
);

  logic [31:0] mem_r [2**DEPTH_LOG2];
  logic [31:0] rd_data_r;

  // byte-lane write and registered read port
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_data_r <= mem_r[rd_idx];
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit: request latch, wait-state FSM, byte lanes, load extension, error flags.
// Build option: define LSU_MISALIGN_TRAP_EN to flag misaligned H/W accesses as errors.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int AW = DEPTH_LOG2 + 2;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             we_r;
  logic [2:0]       f3_r;
  logic [AW-1:0]    addr_r;
  logic [31:0]      wdata_r;
  logic             rsp_valid_r, rsp_err_r;
  logic [31:0]      rsp_rdata_r;

  logic             accept_s, exec_s, illegal_s, err_s;
  logic [1:0]       off_s;
  logic [3:0]       be_s, wr_be_s;
  logic [31:0]      wd_s, sh_s, ld_s, rdata_s, rd_data_s;
  logic [DEPTH_LOG2-1:0] rd_idx_s;
  logic             unused_addr_s;

  assign unused_addr_s = ^req_addr[ADDR_WIDTH-1:AW];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_s;
  assign misal_s = ((f3_r[1:0] == 2'b01) && addr_r[0]) ||
                   ((f3_r[1:0] == 2'b10) && (addr_r[1:0] != 2'b00));
  assign err_s   = illegal_s | misal_s;
`else
  assign err_s   = illegal_s;
`endif

  // width legality, lane selection, store replication and load extension
  always_comb begin
    illegal_s = 1'b1;
    off_s     = 2'b00;
    be_s      = 4'b1111;
    wd_s      = wdata_r;
    ld_s      = 32'h0000_0000;
    case (f3_r)
      F3_B, F3_H, F3_W: illegal_s = 1'b0;
      F3_BU, F3_HU:     illegal_s = we_r;
      default:          illegal_s = 1'b1;
    endcase
    // misaligned offset bits are dropped here; the trap build flags them via err_s
    case (f3_r[1:0])
      2'b00: begin
        off_s = addr_r[1:0];
        be_s  = 4'b0001 << addr_r[1:0];
        wd_s  = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        off_s = {addr_r[1], 1'b0};
        be_s  = 4'b0011 << {addr_r[1], 1'b0};
        wd_s  = {2{wdata_r[15:0]}};
      end
      default: begin
        off_s = 2'b00;
        be_s  = 4'b1111;
        wd_s  = wdata_r;
      end
    endcase
    sh_s = rd_data_s >> {off_s, 3'b000};
    case (f3_r)
      F3_B:    ld_s = {{24{sh_s[7]}}, sh_s[7:0]};
      F3_BU:   ld_s = {24'h00_0000, sh_s[7:0]};
      F3_H:    ld_s = {{16{sh_s[15]}}, sh_s[15:0]};
      F3_HU:   ld_s = {16'h0000, sh_s[15:0]};
      F3_W:    ld_s = sh_s;
      default: ld_s = 32'h0000_0000;
    endcase
  end

  assign rdata_s  = (we_r || err_s) ? 32'h0000_0000 : ld_s;
  assign wr_be_s  = (exec_s && we_r && !err_s && clear) ? be_s : 4'b0000;
  // while idle the array looks at the incoming address so LATENCY=0 has data in time
  assign rd_idx_s = (state_r == IDLE) ? req_addr[AW-1:2] : addr_r[AW-1:2];

  lsu_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clock   (clock),
    .wr_be   (wr_be_s),
    .wr_idx  (addr_r[AW-1:2]),
    .wr_data (wd_s),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s)
  );

  // next-state and accept/execute strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    exec_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && clear) begin
          accept_s = 1'b1;
          state_s  = WAIT;
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          exec_s  = 1'b1;
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // request latch, wait counter and registered response
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt_r       <= {CNT_W{1'b0}};
      we_r        <= 1'b0;
      f3_r        <= 3'b000;
      addr_r      <= {AW{1'b0}};
      wdata_r     <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        f3_r    <= req_funct3;
        addr_r  <= req_addr[AW-1:0];
        wdata_r <= req_wdata;
        cnt_r   <= CNT_W'(LATENCY);
      end else if ((state_r == WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (exec_s) begin
        rsp_valid_r <= 1'b1;
        rsp_rdata_r <= rdata_s;
        rsp_err_r   <= err_s;
      end else if ((state_r == RESP) && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign req_ready = (state_r == IDLE) && clear;
  assign busy      = (state_r != IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: a LATENCY=2 and a LATENCY=0 instance share stimulus
// and are checked against constants and a byte-level memory model.
module tb_lsu_mem;
  import lsu_pkg::*;

  localparam int LAT2 = 3;
  localparam int LAT0 = 1;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
  } op_t;

  logic        clock, clear, req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready2, rsp_valid2, rsp_err2, busy2;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] rsp_rdata2, rsp_rdata0;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_m [64];

  lsu_mem #(.ADDR_WIDTH(32), .DEPTH_LOG2(6), .LATENCY(2)) dut2 (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2),
    .rsp_err(rsp_err2), .busy(busy2)
  );

  lsu_mem #(.ADDR_WIDTH(32), .DEPTH_LOG2(6), .LATENCY(0)) dut0 (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .busy(busy0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: byte-addressed view of the word memory (64 words, aliasing on addr[7:2]).
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int size, off, idx;
    bit legal, misal;
    logic [31:0] v;
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(we && f3[2]);
    size  = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    idx   = int'(addr[7:2]);
    misal = (off % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = !legal || misal;
`else
    err = !legal;
`endif
    off = off - (off % size);
    rd  = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mem_m[idx][8*(off+i) +: 8] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[idx][8*(off+i) +: 8];
      if (!f3[2]) for (int b = 8*size; b < 32; b++) v[b] = v[8*size-1];
      rd = v;
    end
  endfunction

  // Drives one request into both DUTs, records each response and its latency, optionally
  // holds rsp_ready low for 'hold' cycles while watching for any change, then consumes it.
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd2, output logic err2, output int lat2,
                        output logic [31:0] rd0, output logic err0, output int lat0,
                        output bit rdy_ok, output bit stable);
    @(negedge clock);
    rdy_ok     = (req_ready2 === 1'b1) && (req_ready0 === 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat2 = -1; lat0 = -1; rd2 = 32'h0; rd0 = 32'h0; err2 = 1'b0; err0 = 1'b0;
    for (int c = 1; c <= 40 && (lat2 < 0 || lat0 < 0); c++) begin
      @(posedge clock);
      #1;
      if (rsp_valid2 === 1'b1 && lat2 < 0) begin lat2 = c; rd2 = rsp_rdata2; err2 = rsp_err2; end
      if (rsp_valid0 === 1'b1 && lat0 < 0) begin lat0 = c; rd0 = rsp_rdata0; err0 = rsp_err0; end
    end
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== rd2 || rsp_err2 !== err2 || req_ready2 !== 1'b0 ||
          busy2 !== 1'b1 || rsp_valid0 !== 1'b1 || rsp_rdata0 !== rd0 || rsp_err0 !== err0 ||
          req_ready0 !== 1'b0) stable = 1'b0;
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({rsp_valid2, rsp_rdata2, rsp_err2, busy2, req_ready2} !== 36'h0 ||
        {rsp_valid0, rsp_rdata0, rsp_err0, busy0, req_ready0} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b rd=%h e=%b busy=%b rdy=%b / v=%b rd=%h e=%b busy=%b rdy=%b want all 0",
               rsp_valid2, rsp_rdata2, rsp_err2, busy2, req_ready2,
               rsp_valid0, rsp_rdata0, rsp_err0, busy0, req_ready0);
    end
    @(negedge clock);
    clear = 1'b1;
    #1;
    checks++;
    if (req_ready2 !== 1'b1 || req_ready0 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got req_ready=%b/%b busy=%b want 1/1 busy=0", req_ready2, req_ready0, busy2);
    end
  endtask

  task automatic test_word();
    op_t q[$];
    logic [31:0] r2, r0; logic e2, e0; int l2, l0; bit ok, st;
    q.push_back(op_t'{1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
    q.push_back(op_t'{1'b0, F3_W, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});
    q.push_back(op_t'{1'b0, F3_W, 32'h0000_0110, 32'h0, 32'hDEAD_BEEF, 1'b0});
    q.push_back(op_t'{1'b0, F3_W, 32'hABCD_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});
    foreach (q[i]) begin
      access(q[i].we, q[i].f3, q[i].addr, q[i].wd, 0, r2, e2, l2, r0, e0, l0, ok, st);
      checks++;
      if ({r2, e2} !== {q[i].exp, q[i].err} || {r0, e0} !== {q[i].exp, q[i].err} ||
          l2 != LAT2 || l0 != LAT0 || !ok) begin
        errors++;
        $display("FAIL word[%0d] got rd=%h/%h err=%b/%b lat=%0d/%0d rdy=%b want rd=%h err=%b lat=%0d/%0d rdy=1",
                 i, r2, r0, e2, e0, l2, l0, ok, q[i].exp, q[i].err, LAT2, LAT0);
      end
    end
  endtask

  task automatic test_byte_half();
    op_t q[$];
    logic [31:0] r2, r0; logic e2, e0; int l2, l0; bit ok, st;
    q.push_back(op_t'{1'b1, F3_B,  32'h13, 32'h0000_0080, 32'h0, 1'b0});
    q.push_back(op_t'{1'b0, F3_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0});
    q.push_back(op_t'{1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0});
    q.push_back(op_t'{1'b0, F3_W,  32'h10, 32'h0, 32'h80AD_BEEF, 1'b0});
    q.push_back(op_t'{1'b0, F3_B,  32'h12, 32'h0, 32'hFFFF_FFAD, 1'b0});
    q.push_back(op_t'{1'b1, F3_W,  32'h20, 32'h0, 32'h0, 1'b0});
    q.push_back(op_t'{1'b1, F3_H,  32'h22, 32'hFFFF_8234, 32'h0, 1'b0});
    q.push_back(op_t'{1'b0, F3_H,  32'h22, 32'h0, 32'hFFFF_8234, 1'b0});
    q.push_back(op_t'{1'b0, F3_HU, 32'h22, 32'h0, 32'h0000_8234, 1'b0});
    q.push_back(op_t'{1'b0, F3_W,  32'h20, 32'h0, 32'h8234_0000, 1'b0});
    q.push_back(op_t'{1'b0, F3_BU, 32'h23, 32'h0, 32'h0000_0082, 1'b0});
    q.push_back(op_t'{1'b0, F3_B,  32'h21, 32'h0, 32'h0000_0000, 1'b0});
    foreach (q[i]) begin
      access(q[i].we, q[i].f3, q[i].addr, q[i].wd, 0, r2, e2, l2, r0, e0, l0, ok, st);
      checks++;
      if ({r2, e2} !== {q[i].exp, q[i].err} || {r0, e0} !== {q[i].exp, q[i].err} ||
          l2 != LAT2 || l0 != LAT0 || !ok) begin
        errors++;
        $display("FAIL byte_half[%0d] got rd=%h/%h err=%b/%b lat=%0d/%0d rdy=%b want rd=%h err=%b lat=%0d/%0d rdy=1",
                 i, r2, r0, e2, e0, l2, l0, ok, q[i].exp, q[i].err, LAT2, LAT0);
      end
    end
  endtask

  task automatic test_misalign();
    op_t q[$];
    logic [31:0] r2, r0; logic e2, e0; int l2, l0; bit ok, st;
`ifdef LSU_MISALIGN_TRAP_EN
    q.push_back(op_t'{1'b0, F3_W,  32'h11, 32'h0, 32'h0, 1'b1});
    q.push_back(op_t'{1'b0, F3_H,  32'h13, 32'h0, 32'h0, 1'b1});
    q.push_back(op_t'{1'b0, F3_HU, 32'h23, 32'h0, 32'h0, 1'b1});
    q.push_back(op_t'{1'b1, F3_H,  32'h21, 32'h0000_5555, 32'h0, 1'b1});
    q.push_back(op_t'{1'b0, F3_W,  32'h20, 32'h0, 32'h8234_0000, 1'b0});
`else
    q.push_back(op_t'{1'b0, F3_W,  32'h11, 32'h0, 32'h80AD_BEEF, 1'b0});
    q.push_back(op_t'{1'b0, F3_H,  32'h13, 32'h0, 32'hFFFF_80AD, 1'b0});
    q.push_back(op_t'{1'b0, F3_HU, 32'h23, 32'h0, 32'h0000_8234, 1'b0});
    q.push_back(op_t'{1'b1, F3_H,  32'h21, 32'h0000_5555, 32'h0, 1'b0});
    q.push_back(op_t'{1'b0, F3_W,  32'h20, 32'h0, 32'h8234_5555, 1'b0});
`endif
    foreach (q[i]) begin
      access(q[i].we, q[i].f3, q[i].addr, q[i].wd, 0, r2, e2, l2, r0, e0, l0, ok, st);
      checks++;
      if ({r2, e2} !== {q[i].exp, q[i].err} || {r0, e0} !== {q[i].exp, q[i].err} ||
          l2 != LAT2 || l0 != LAT0 || !ok) begin
        errors++;
        $display("FAIL misalign[%0d] got rd=%h/%h err=%b/%b lat=%0d/%0d rdy=%b want rd=%h err=%b lat=%0d/%0d rdy=1",
                 i, r2, r0, e2, e0, l2, l0, ok, q[i].exp, q[i].err, LAT2, LAT0);
      end
    end
  endtask

  task automatic test_illegal();
    op_t q[$];
    logic [31:0] r2, r0; logic e2, e0; int l2, l0; bit ok, st;
    q.push_back(op_t'{1'b1, F3_W,   32'h30, 32'h1111_1111, 32'h0, 1'b0});
    q.push_back(op_t'{1'b1, 3'b011, 32'h30, 32'h2222_2222, 32'h0, 1'b1});
    q.push_back(op_t'{1'b1, F3_BU,  32'h30, 32'h3333_3333, 32'h0, 1'b1});
    q.push_back(op_t'{1'b1, F3_HU,  32'h30, 32'h4444_4444, 32'h0, 1'b1});
    q.push_back(op_t'{1'b1, 3'b111, 32'h30, 32'h5555_5555, 32'h0, 1'b1});
    q.push_back(op_t'{1'b0, F3_W,   32'h30, 32'h0, 32'h1111_1111, 1'b0});
    q.push_back(op_t'{1'b0, 3'b110, 32'h30, 32'h0, 32'h0, 1'b1});
    q.push_back(op_t'{1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b1});
    foreach (q[i]) begin
      access(q[i].we, q[i].f3, q[i].addr, q[i].wd, 0, r2, e2, l2, r0, e0, l0, ok, st);
      checks++;
      if ({r2, e2} !== {q[i].exp, q[i].err} || {r0, e0} !== {q[i].exp, q[i].err} ||
          l2 != LAT2 || l0 != LAT0 || !ok) begin
        errors++;
        $display("FAIL illegal[%0d] got rd=%h/%h err=%b/%b lat=%0d/%0d rdy=%b want rd=%h err=%b lat=%0d/%0d rdy=1",
                 i, r2, r0, e2, e0, l2, l0, ok, q[i].exp, q[i].err, LAT2, LAT0);
      end
    end
  endtask

  task automatic test_clear_mid();
    logic [31:0] r2, r0; logic e2, e0; int l2, l0; bit ok, st, seen;
    access(1'b1, F3_W, 32'h40, 32'hAAAA_AAAA, 0, r2, e2, l2, r0, e0, l0, ok, st);
    checks++;
    if ({r2, e2, r0, e0} !== 66'h0 || l2 != LAT2 || l0 != LAT0 || !ok) begin
      errors++;
      $display("FAIL clear_pre_store got rd=%h/%h err=%b/%b lat=%0d/%0d want 0/0 0/0 %0d/%0d",
               r2, r0, e2, e0, l2, l0, LAT2, LAT0);
    end
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h5;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0 || req_ready2 !== 1'b0 ||
        rsp_valid0 !== 1'b0 || req_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL clear_low got v=%b busy=%b rdy=%b v0=%b rdy0=%b want 0 0 0 0 0",
               rsp_valid2, busy2, req_ready2, rsp_valid0, req_ready0);
    end
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1;
    checks++;
    if (req_ready2 !== 1'b1 || req_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_release got req_ready=%b/%b want 1/1", req_ready2, req_ready0);
    end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (rsp_valid2 !== 1'b0 || rsp_valid0 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL clear_no_rsp got rsp_valid after dropped access want none");
    end
    access(1'b0, F3_W, 32'h40, 32'h0, 0, r2, e2, l2, r0, e0, l0, ok, st);
    checks++;
    if ({r2, e2} !== {32'hAAAA_AAAA, 1'b0} || {r0, e0} !== {32'hAAAA_AAAA, 1'b0} || !ok) begin
      errors++;
      $display("FAIL clear_old_data got rd=%h/%h err=%b/%b rdy=%b want aaaaaaaa err=0", r2, r0, e2, e0, ok);
    end
  endtask

  task automatic test_hold();
    logic [31:0] r2, r0; logic e2, e0; int l2, l0; bit ok, st;
    access(1'b0, F3_W, 32'h10, 32'h0, 5, r2, e2, l2, r0, e0, l0, ok, st);
    checks++;
    if (!st || r2 !== 32'h80AD_BEEF || r0 !== 32'h80AD_BEEF || e2 !== 1'b0 || l2 != LAT2) begin
      errors++;
      $display("FAIL hold got stable=%b rd=%h/%h err=%b lat=%0d want stable=1 rd=80adbeef err=0 lat=%0d",
               st, r2, r0, e2, l2, LAT2);
    end
  endtask

  task automatic test_random();
    logic [31:0] r2, r0, er, a, d; logic e2, e0, ee; int l2, l0; bit ok, st, we;
    logic [2:0] f3;
    for (int i = 0; i < 64; i++) begin
      a = {$urandom} & 32'hFFFF_FF00 | (i << 2);
      d = $urandom;
      model(1'b1, F3_W, a, d, er, ee);
      access(1'b1, F3_W, a, d, 0, r2, e2, l2, r0, e0, l0, ok, st);
      checks++;
      if ({r2, e2, r0, e0} !== {er, ee, er, ee} || l2 != LAT2 || l0 != LAT0 || !ok) begin
        errors++;
        $display("FAIL rand_init[%0d] got rd=%h/%h err=%b/%b lat=%0d/%0d want rd=%h err=%b", i, r2, r0, e2, e0, l2, l0, er, ee);
      end
    end
    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      d  = $urandom;
      model(we, f3, a, d, er, ee);
      access(we, f3, a, d, 0, r2, e2, l2, r0, e0, l0, ok, st);
      checks++;
      if ({r2, e2, r0, e0} !== {er, ee, er, ee} || l2 != LAT2 || l0 != LAT0 || !ok) begin
        errors++;
        $display("FAIL rand[%0d] we=%b f3=%b addr=%h wd=%h got rd=%h/%h err=%b/%b lat=%0d/%0d rdy=%b want rd=%h err=%b",
                 i, we, f3, a, d, r2, r0, e2, e0, l2, l0, ok, er, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_illegal();
    test_clear_mid();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
